uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named CLK and RESET_N.
REQ-002 Parameter NUM_REQ, default 3, SHALL set the number of requesters (fixed range 2..4).
REQ-003 Parameter BUSY_TIMEOUT, default 16, SHALL set the maximum number of cycles to wait for TXRDY to fall after a write.
REQ-004 Parameter LOCK_TIMEOUT, default 255, SHALL set the maximum number of idle cycles a packet lock may be held.
REQ-005 Ports SHALL be as follows:
- CLK  in  1  fabric clock (FAB_CCC_GL0 domain).
- RESET_N  in  1  async active-low reset.
- REQ_VALID  in  NUM_REQ  per-requester byte valid.
- REQ_DATA  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- REQ_LAST  in  NUM_REQ  per-requester last byte of packet.
- REQ_READY  out  NUM_REQ  per-requester byte-accepted strobe.
- TXRDY  in  1  fabric UART transmit holding register empty.
- UART_WEN_N  out  1  fabric UART write strobe, active-low.
- UART_DATA  out  8  byte presented to the fabric UART.
- GRANT  out  NUM_REQ  one-hot current owner.
- BUSY  out  1  high whenever the state is not IDLE.
- TIMEOUT_ERR  out  1  sticky; high after any busy timeout.

Function
REQ-006 Handshake: a byte SHALL transfer on a cycle where REQ_VALID[i]=1 and REQ_READY[i]=1; the requester SHALL hold VALID, DATA and LAST stable until that transfer.
REQ-007 The FSM SHALL have five states: IDLE, LOAD, WAIT_BUSY, WAIT_RDY and HOLD.
REQ-008 IDLE: when TXRDY=1 and any REQ_VALID=1, the block SHALL pick a winner by round-robin (the first index at or after PTR, wrapping), register GRANT, UART_DATA=REQ_DATA[winner], UART_WEN_N=0 and REQ_READY[winner]=1, and enter LOAD.
REQ-009 LOAD SHALL last exactly 1 cycle, with UART_WEN_N=0 and REQ_READY one-hot for that cycle; PTR SHALL become winner+1 mod NUM_REQ; LAST SHALL be latched into lock_n; the next state SHALL be WAIT_BUSY.
REQ-010 Latency SHALL be 1 cycle from the IDLE decision to the write strobe, so a byte from a VALID asserted with TXRDY=1 is written 2 cycles later.
REQ-011 WAIT_BUSY: TXRDY=0 SHALL cause a move to WAIT_RDY; after BUSY_TIMEOUT cycles with TXRDY=1 the block SHALL set TIMEOUT_ERR and proceed as if TXRDY had fallen.
REQ-012 WAIT_RDY: when TXRDY=1, the block SHALL go to IDLE if the latched LAST=1, else to HOLD.
REQ-013 HOLD: GRANT SHALL be kept, and other requesters SHALL be ignored.
REQ-014 In HOLD, if REQ_VALID[owner]=1 the block SHALL load as in REQ-008 for the owner only.
REQ-015 In HOLD, after LOCK_TIMEOUT consecutive cycles without owner VALID, the block SHALL release the lock, clear GRANT and return to IDLE.
REQ-016 If multiple VALIDs arrive in the same cycle, exactly one SHALL be granted; the losers SHALL get no READY and SHALL keep waiting.
REQ-017 If TXRDY=0 in IDLE, no grant SHALL occur.
REQ-018 GRANT SHALL be 0 in IDLE and one-hot in every other state.
REQ-019 The idle and busy counters SHALL saturate and never wrap.
REQ-020 Only RESET_N SHALL clear TIMEOUT_ERR.

Reset
REQ-021 During reset: UART_WEN_N=1, UART_DATA=0x00, REQ_READY=0, GRANT=0, BUSY=0, TIMEOUT_ERR=0, PTR=0, counters=0, state=IDLE.
REQ-022 Assertion of RESET_N mid-transfer SHALL force UART_WEN_N high immediately (asynchronously) and abandon any packet lock.
REQ-023 Deassertion of RESET_N SHALL be treated as synchronized externally; the block SHALL be ready for a grant on the first clock edge after deassertion.

Structure
REQ-024 Shared package uart_arb_pkg SHALL hold the FSM state type, the default values of NUM_REQ, BUSY_TIMEOUT and LOCK_TIMEOUT, and the byte-width constant (8).
REQ-025 Sub-module rr_pick SHALL be a combinational round-robin selector (inputs: request vector and PTR; outputs: one-hot winner and an any flag), instantiated once.
REQ-026 All outputs SHALL be driven directly from registers, with no combinational paths from inputs to outputs.

Verification
REQ-027 Single byte: REQ_VALID[0]=1, DATA=0x41, LAST=1, TXRDY=1 -> UART_WEN_N low for 1 cycle 2 cycles later, UART_DATA=0x41, REQ_READY[0] pulse, return to IDLE once TXRDY goes 0 then 1.
REQ-028 Round-robin: all three VALID held with LAST=1 -> grant order 0,1,2,0; UART_DATA sequence matches per-requester bytes.
REQ-029 Packet lock: req1 sends 0x10,0x11,0x12 (LAST on 0x12) while req0 VALID is held -> all three req1 bytes are sent contiguously before any req0 byte.
REQ-030 Busy timeout: TXRDY stuck at 1 after the write -> TIMEOUT_ERR=1 after 16 cycles, FSM returns to IDLE, flag stays high.
REQ-031 Lock release: req2 sends a byte with LAST=0 then drops VALID -> GRANT clears after 255 idle cycles, and a pending req0 is then granted.
REQ-032 Reset mid-LOAD: pull RESET_N low during the UART_WEN_N=0 cycle -> UART_WEN_N=1 immediately, all outputs at reset values, PTR=0.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared FSM state type, default parameters and byte width
// for the UART transmit arbiter.
package uart_arb_pkg;
   localparam int BYTE_W           = 8;
   localparam int DEF_NUM_REQ      = 3;
   localparam int DEF_BUSY_TIMEOUT = 16;
   localparam int DEF_LOCK_TIMEOUT = 255;
   typedef enum logic [2:0] {IDLE, LOAD, WAIT_BUSY, WAIT_RDY, HOLD} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector; the first requester at or
// after ptr (wrapping) wins.
module rr_pick #(
   parameter int N  = 3,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic          any
);
   always_comb begin
      gnt = '0;
      // walk offsets from farthest to nearest so the nearest valid index wins
      for (int k = N - 1; k >= 0; k--)
         for (int j = 0; j < N; j++)
            if (req[j] && j == (int'(ptr) + k) % N) gnt = N'(1) << j;
   end
   assign any = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding bytes from several requesters
// into a fabric UART, with packet locking and busy/lock timeouts.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ      = DEF_NUM_REQ,
   parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
   parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
   input  logic                      CLK,
   input  logic                      RESET_N,
   input  logic [NUM_REQ-1:0]        REQ_VALID,
   input  logic [BYTE_W*NUM_REQ-1:0] REQ_DATA,
   input  logic [NUM_REQ-1:0]        REQ_LAST,
   output logic [NUM_REQ-1:0]        REQ_READY,
   input  logic                      TXRDY,
   output logic                      UART_WEN_N,
   output logic [BYTE_W-1:0]         UART_DATA,
   output logic [NUM_REQ-1:0]        GRANT,
   output logic                      BUSY,
   output logic                      TIMEOUT_ERR
);
   localparam int PW = $clog2(NUM_REQ);
   localparam int CW = $clog2((BUSY_TIMEOUT > LOCK_TIMEOUT ? BUSY_TIMEOUT : LOCK_TIMEOUT) + 1);

   state_t              state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d, ready_q, ready_d, win;
   logic [BYTE_W-1:0]   data_q, data_d, win_data, own_data;
   logic                wen_n_q, wen_n_d, busy_q, busy_d, err_q, err_d, last_q, last_d;
   logic                any, own_valid, own_last;
   logic [PW-1:0]       ptr_q, ptr_d, ptr_nxt;
   logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;

   rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (.req(REQ_VALID), .ptr(ptr_q), .gnt(win), .any(any));

   always_comb begin
      win_data = '0;
      own_data = '0;
      ptr_nxt  = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (win[j]) win_data = REQ_DATA[j*BYTE_W +: BYTE_W];
         if (grant_q[j]) begin
            own_data = REQ_DATA[j*BYTE_W +: BYTE_W];
            ptr_nxt  = PW'((j + 1) % NUM_REQ);
         end
      end
      own_valid = |(REQ_VALID & grant_q);
      own_last  = |(REQ_LAST & grant_q);
      cnt_inc   = &cnt_q ? cnt_q : cnt_q + CW'(1);
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ready_d = '0;
      data_d  = data_q;
      wen_n_d = 1'b1;
      ptr_d   = ptr_q;
      last_d  = last_q;
      err_d   = err_q;
      cnt_d   = '0;
      case (state_q)
         IDLE: if (TXRDY && any) begin
            state_d = LOAD;
            grant_d = win;
            ready_d = win;
            data_d  = win_data;
            wen_n_d = 1'b0;
         end
         LOAD: begin
            state_d = WAIT_BUSY;
            ptr_d   = ptr_nxt;
            last_d  = own_last;
         end
         // a UART that never drops TXRDY is treated as having accepted the byte
         WAIT_BUSY: if (!TXRDY) state_d = WAIT_RDY;
            else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = WAIT_RDY;
            end else cnt_d = cnt_inc;
         WAIT_RDY: if (TXRDY) begin
            state_d = last_q ? IDLE : HOLD;
            grant_d = last_q ? '0 : grant_q;
         end
         HOLD: if (own_valid && TXRDY) begin
            state_d = LOAD;
            ready_d = grant_q;
            data_d  = own_data;
            wen_n_d = 1'b0;
         end else if (!own_valid) begin
            if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
               state_d = IDLE;
               grant_d = '0;
            end else cnt_d = cnt_inc;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         grant_q <= '0;
         ready_q <= '0;
         data_q  <= '0;
         wen_n_q <= 1'b1;
         ptr_q   <= '0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ready_q <= ready_d;
         data_q  <= data_d;
         wen_n_q <= wen_n_d;
         ptr_q   <= ptr_d;
         last_q  <= last_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
      end
   end

   assign GRANT       = grant_q;
   assign REQ_READY   = ready_q;
   assign UART_DATA   = data_q;
   assign UART_WEN_N  = wen_n_q;
   assign BUSY        = busy_q;
   assign TIMEOUT_ERR = err_q;
endmodule
